ptw_req_arbiter: RTL and testbench
==================================

Name: ptw_req_arbiter

Overview:
- Shares one SV39 page-table walker between the instruction TLB and the data TLB.
- Accepts miss requests from both TLBs and arbitrates them round-robin, one walk in flight at a time.
- Forwards the winning request to the walker, then routes the walker's tlb_update_t (or error) back to the requesting TLB only.
- Handles flushes arriving before or during a walk so that no stale entry is ever written.

Parameters:
- ASID_WIDTH, 1, width of the address-space ID carried with each request and update.
- VADDR_WIDTH, 64, width of the virtual address.

Ports:
- clk_i  in  1  clock; only clock.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  TLB/walk flush (sfence.vma).
- itlb_req_i  in  1  ITLB miss request; held high until itlb_gnt_o.
- itlb_vaddr_i  in  VADDR_WIDTH  ITLB miss address.
- itlb_asid_i  in  ASID_WIDTH  ITLB ASID.
- itlb_gnt_o  out  1  one-cycle accept pulse.
- dtlb_req_i, dtlb_vaddr_i, dtlb_asid_i, dtlb_gnt_o  as above, for the DTLB.
- ptw_req_o  out  1  walk request to the walker.
- ptw_vaddr_o  out  VADDR_WIDTH  latched address of the walk.
- ptw_asid_o  out  ASID_WIDTH  latched ASID of the walk.
- ptw_ready_i  in  1  walker accepts the request.
- ptw_done_i  in  1  walk complete (single-cycle pulse).
- ptw_update_i  in  tlb_update_t  walk result.
- ptw_error_i  in  1  page fault/access error, valid with ptw_done_i.
- itlb_update_o  out  tlb_update_t  update routed to the ITLB.
- dtlb_update_o  out  tlb_update_t  update routed to the DTLB.
- itlb_error_o, dtlb_error_o  out  1  routed fault pulse.
- busy_o  out  1  state != IDLE.

Behaviour:
- State register: IDLE, REQ, WALK, DRAIN. Also src_q (0 = I, 1 = D), last_q (last granted source), vaddr_q, asid_q.
- Reset (synchronous, rst_i=1): state=IDLE, last_q=D (so the ITLB wins the first tie), src_q=0, vaddr_q=0, asid_q=0. All outputs 0, including update valid bits.
- IDLE:
  - If flush_i: stay in IDLE.
  - Else if any request: pick the winner. A single requester wins outright; if both request, the winner is the source != last_q.
  - Latch the winner's vaddr/asid into vaddr_q/asid_q and set src_q. Go to REQ next cycle (1-cycle request latency).
  - No gnt is issued in IDLE.
- REQ:
  - ptw_req_o=1; ptw_vaddr_o/ptw_asid_o driven from the registered copies.
  - If flush_i: go to IDLE with no gnt; the requester re-arbitrates later.
  - Else if ptw_ready_i: pulse gnt to src_q in the same cycle, set last_q=src_q, go to WALK.
  - ptw_done_i seen in REQ is a protocol violation and is ignored.
- WALK:
  - On ptw_done_i with no flush: drive <src>_update_o = ptw_update_i and <src>_error_o = ptw_error_i combinationally in that cycle. The other TLB's outputs stay 0. Go to IDLE.
  - If flush_i without done: go to DRAIN.
  - If flush_i and ptw_done_i in the same cycle: discard the result (valid=0, error=0) and go to IDLE.
- DRAIN: wait for ptw_done_i, discard it, go to IDLE. Requests are not arbitrated in DRAIN.
- update_o.valid is asserted only if ptw_update_i.valid is set. The content fields are passed through regardless, but are meaningful only when valid=1.
- Requests arriving while not in IDLE are held by the requester; at most one walk is outstanding.
- Back-to-back: the earliest next grant is 2 cycles after done (IDLE, then REQ).
- Asserting rst_i in any state returns the block to IDLE on the next edge. Any in-flight result is dropped.

Optional Feature:
- Macro PTW_ARB_PERF_EN.
- With the macro: adds outputs perf_itlb_walks_o[31:0], perf_dtlb_walks_o[31:0] and perf_flush_aborts_o[31:0].
  - Walk counters increment on each gnt to that source.
  - perf_flush_aborts_o increments on each abort out of REQ and each discard in WALK/DRAIN.
  - All three counters saturate at 0xFFFF_FFFF and clear on rst_i.
- Without the macro: the ports are absent and there is no counter logic.

Decomposition:
- Add to ariane_pkg: ptw_arb_state_e (IDLE/REQ/WALK/DRAIN) and ptw_src_e (SRC_ITLB=0, SRC_DTLB=1). tlb_update_t is reused unchanged.
- No sub-module: the 2-way round-robin is a single last_q bit inline.

Test Plan:
- Only ITLB requests, vaddr 0x0000_0040_2000_1000. Required: ptw_req_o on cycle 1 with that vaddr; ptw_ready_i=1 gives itlb_gnt_o in the same cycle; ptw_done_i with update.valid=1 gives itlb_update_o.valid=1 and dtlb_update_o.valid=0.
- Both TLBs request simultaneously after reset. Required: ITLB granted first; with both still requesting, DTLB second, then ITLB third (strict alternation).
- flush_i in REQ with ptw_ready_i=0. Required: IDLE next cycle, no gnt, ptw_req_o=0.
- flush_i in WALK, ptw_done_i 3 cycles later with update.valid=1. Required: DRAIN; both update valid bits stay 0; busy_o falls after done; perf_flush_aborts_o=1 when PTW_ARB_PERF_EN is defined.
- flush_i and ptw_done_i in the same cycle with ptw_error_i=1. Required: no error pulse on either side; IDLE next cycle.
- rst_i asserted in WALK. Required: IDLE next edge; a later ptw_done_i produces no update; the next ITLB/DTLB tie goes to the ITLB.

Source files
------------

// File: rtl/ptw_req_arbiter_pkg.sv
// Shared types for the ITLB/DTLB page-table-walker arbiter: FSM states,
// request source encoding and the TLB update record returned by the walker.
package ptw_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WALK  = 2'd2,
    DRAIN = 2'd3
  } ptw_arb_state_e;

  typedef enum logic {
    SRC_ITLB = 1'b0,
    SRC_DTLB = 1'b1
  } ptw_src_e;

  typedef struct packed {
    logic        valid;
    logic        is_2m;
    logic        is_1g;
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [63:0] content;
  } tlb_update_t;

  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  // Event counters hold at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == PERF_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ptw_req_arbiter.sv
// Round-robin arbiter sharing one SV39 walker between the ITLB and DTLB, with
// flush-safe result routing. Optional event counters behind PTW_ARB_PERF_EN.
module ptw_req_arbiter
  import ptw_req_arbiter_pkg::*;
#(
  parameter int unsigned ASID_WIDTH  = 1,
  parameter int unsigned VADDR_WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   itlb_req_i,
  input  logic [VADDR_WIDTH-1:0] itlb_vaddr_i,
  input  logic [ASID_WIDTH-1:0]  itlb_asid_i,
  output logic                   itlb_gnt_o,
  input  logic                   dtlb_req_i,
  input  logic [VADDR_WIDTH-1:0] dtlb_vaddr_i,
  input  logic [ASID_WIDTH-1:0]  dtlb_asid_i,
  output logic                   dtlb_gnt_o,
  output logic                   ptw_req_o,
  output logic [VADDR_WIDTH-1:0] ptw_vaddr_o,
  output logic [ASID_WIDTH-1:0]  ptw_asid_o,
  input  logic                   ptw_ready_i,
  input  logic                   ptw_done_i,
  input  tlb_update_t            ptw_update_i,
  input  logic                   ptw_error_i,
  output tlb_update_t            itlb_update_o,
  output tlb_update_t            dtlb_update_o,
  output logic                   itlb_error_o,
  output logic                   dtlb_error_o,
  output logic                   busy_o
`ifdef PTW_ARB_PERF_EN
  ,
  output logic [31:0]            perf_itlb_walks_o,
  output logic [31:0]            perf_dtlb_walks_o,
  output logic [31:0]            perf_flush_aborts_o
`endif
);

  ptw_arb_state_e         state_q, state_d;
  ptw_src_e               src_q, src_d;
  ptw_src_e               last_q, last_d;
  ptw_src_e               win;
  logic [VADDR_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [ASID_WIDTH-1:0]  asid_q, asid_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= SRC_ITLB;
      last_q  <= SRC_DTLB;
      vaddr_q <= '0;
      asid_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      last_q  <= last_d;
      vaddr_q <= vaddr_d;
      asid_q  <= asid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    last_d        = last_q;
    vaddr_d       = vaddr_q;
    asid_d        = asid_q;
    win           = SRC_ITLB;
    itlb_gnt_o    = 1'b0;
    dtlb_gnt_o    = 1'b0;
    itlb_update_o = '0;
    dtlb_update_o = '0;
    itlb_error_o  = 1'b0;
    dtlb_error_o  = 1'b0;

    if (itlb_req_i && dtlb_req_i) begin
      win = (last_q == SRC_ITLB) ? SRC_DTLB : SRC_ITLB;
    end else if (dtlb_req_i) begin
      win = SRC_DTLB;
    end

    unique case (state_q)
      IDLE: begin
        if (!flush_i && (itlb_req_i || dtlb_req_i)) begin
          src_d   = win;
          vaddr_d = (win == SRC_DTLB) ? dtlb_vaddr_i : itlb_vaddr_i;
          asid_d  = (win == SRC_DTLB) ? dtlb_asid_i : itlb_asid_i;
          state_d = REQ;
        end
      end
      REQ: begin
        // A done pulse here is a walker protocol error and is not acted on.
        if (flush_i) begin
          state_d = IDLE;
        end else if (ptw_ready_i) begin
          itlb_gnt_o = (src_q == SRC_ITLB);
          dtlb_gnt_o = (src_q == SRC_DTLB);
          last_d     = src_q;
          state_d    = WALK;
        end
      end
      WALK: begin
        if (ptw_done_i) begin
          state_d = IDLE;
          if (!flush_i) begin
            if (src_q == SRC_ITLB) begin
              itlb_update_o = ptw_update_i;
              itlb_error_o  = ptw_error_i;
            end else begin
              dtlb_update_o = ptw_update_i;
              dtlb_error_o  = ptw_error_i;
            end
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ptw_done_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset wins over anything the current state would emit this cycle.
    if (rst_i) begin
      itlb_gnt_o    = 1'b0;
      dtlb_gnt_o    = 1'b0;
      itlb_update_o = '0;
      dtlb_update_o = '0;
      itlb_error_o  = 1'b0;
      dtlb_error_o  = 1'b0;
    end
  end

  assign ptw_req_o   = (state_q == REQ) && !rst_i;
  assign ptw_vaddr_o = vaddr_q;
  assign ptw_asid_o  = asid_q;
  assign busy_o      = (state_q != IDLE) && !rst_i;

`ifdef PTW_ARB_PERF_EN
  logic abort;

  // Aborted requests and every discarded walk result count as flush aborts.
  assign abort = ((state_q == REQ) && flush_i) ||
                 ((state_q == WALK) && flush_i && ptw_done_i) ||
                 ((state_q == DRAIN) && ptw_done_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_itlb_walks_o   <= '0;
      perf_dtlb_walks_o   <= '0;
      perf_flush_aborts_o <= '0;
    end else begin
      if (itlb_gnt_o) perf_itlb_walks_o <= sat_inc(perf_itlb_walks_o);
      if (dtlb_gnt_o) perf_dtlb_walks_o <= sat_inc(perf_dtlb_walks_o);
      if (abort)      perf_flush_aborts_o <= sat_inc(perf_flush_aborts_o);
    end
  end
`endif

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Scoreboard bench for ptw_req_arbiter: expected grants and routed updates are
// queued when stimulus is driven and compared when the DUT responds.
module tb_ptw_req_arbiter;
  import ptw_req_arbiter_pkg::*;

  localparam logic [63:0] IVA = 64'h0000_0040_2000_1000;
  localparam logic [63:0] DVA = 64'h0000_0040_2000_3000;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        itlb_req_i, dtlb_req_i, itlb_gnt_o, dtlb_gnt_o;
  logic [63:0] itlb_vaddr_i, dtlb_vaddr_i, ptw_vaddr_o;
  logic [0:0]  itlb_asid_i, dtlb_asid_i, ptw_asid_o;
  logic        ptw_req_o, ptw_ready_i, ptw_done_i, ptw_error_i;
  tlb_update_t ptw_update_i, itlb_update_o, dtlb_update_o;
  logic        itlb_error_o, dtlb_error_o, busy_o;
`ifdef PTW_ARB_PERF_EN
  logic [31:0] perf_itlb_walks_o, perf_dtlb_walks_o, perf_flush_aborts_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [1:0] gq[$];
  logic [3:0] uq[$];

  always #5 clk_i = ~clk_i;

  ptw_req_arbiter #(.ASID_WIDTH(1), .VADDR_WIDTH(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .itlb_req_i(itlb_req_i), .itlb_vaddr_i(itlb_vaddr_i), .itlb_asid_i(itlb_asid_i),
    .itlb_gnt_o(itlb_gnt_o),
    .dtlb_req_i(dtlb_req_i), .dtlb_vaddr_i(dtlb_vaddr_i), .dtlb_asid_i(dtlb_asid_i),
    .dtlb_gnt_o(dtlb_gnt_o),
    .ptw_req_o(ptw_req_o), .ptw_vaddr_o(ptw_vaddr_o), .ptw_asid_o(ptw_asid_o),
    .ptw_ready_i(ptw_ready_i), .ptw_done_i(ptw_done_i), .ptw_update_i(ptw_update_i),
    .ptw_error_i(ptw_error_i),
    .itlb_update_o(itlb_update_o), .dtlb_update_o(dtlb_update_o),
    .itlb_error_o(itlb_error_o), .dtlb_error_o(dtlb_error_o), .busy_o(busy_o)
`ifdef PTW_ARB_PERF_EN
    ,
    .perf_itlb_walks_o(perf_itlb_walks_o), .perf_dtlb_walks_o(perf_dtlb_walks_o),
    .perf_flush_aborts_o(perf_flush_aborts_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Grant sources are {itlb,dtlb}; updates are {iv,dv,ie,de}.
  always @(negedge clk_i) begin
    if (itlb_gnt_o || dtlb_gnt_o) begin
      if (gq.size() == 0) chk("gnt_unexpected", {itlb_gnt_o, dtlb_gnt_o}, 2'b00);
      else chk("gnt_src", {itlb_gnt_o, dtlb_gnt_o}, gq.pop_front());
    end
    if (ptw_done_i) begin
      if (uq.size() == 0)
        chk("upd_unexpected", {itlb_update_o.valid, dtlb_update_o.valid, itlb_error_o, dtlb_error_o}, 4'b0);
      else begin
        chk("upd_route", {itlb_update_o.valid, dtlb_update_o.valid, itlb_error_o, dtlb_error_o},
            uq.pop_front());
        if (itlb_update_o.valid) chk("upd_vpn_i", itlb_update_o.vpn, ptw_update_i.vpn);
        if (dtlb_update_o.valid) chk("upd_vpn_d", dtlb_update_o.vpn, ptw_update_i.vpn);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1; flush_i = 1'b0;
    itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
    ptw_ready_i = 1'b0; ptw_done_i = 1'b0; ptw_error_i = 1'b0;
    ptw_update_i = '0;
    cyc();
    @(negedge clk_i);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_req", ptw_req_o, 1'b0);
    chk("rst_upd", {itlb_update_o.valid, dtlb_update_o.valid, itlb_error_o, dtlb_error_o}, 4'b0);
    cyc();
    rst_i = 1'b0;
  endtask

  // Entered in a REQ cycle; leaves at the middle of the following IDLE cycle.
  task automatic grant_and_done(input logic src, input logic [63:0] va, input logic drop,
                                input logic err);
    ptw_ready_i = 1'b1;
    gq.push_back(src ? 2'b01 : 2'b10);
    @(negedge clk_i);
    chk("req_hi", ptw_req_o, 1'b1);
    chk("req_vaddr", ptw_vaddr_o, va);
    cyc();
    ptw_ready_i = 1'b0;
    if (drop) begin
      if (src) dtlb_req_i = 1'b0;
      else itlb_req_i = 1'b0;
    end
    @(negedge clk_i);
    chk("walk_busy", busy_o, 1'b1);
    chk("walk_noreq", ptw_req_o, 1'b0);
    cyc();
    ptw_done_i = 1'b1; ptw_error_i = err;
    ptw_update_i.valid = 1'b1; ptw_update_i.vpn = va[38:12];
    uq.push_back(src ? {2'b01, 1'b0, err} : {2'b10, err, 1'b0});
    cyc();
    ptw_done_i = 1'b0; ptw_error_i = 1'b0; ptw_update_i = '0;
    @(negedge clk_i);
    chk("idle_busy", busy_o, 1'b0);
  endtask

  initial begin
    itlb_vaddr_i = IVA; dtlb_vaddr_i = DVA;
    itlb_asid_i = 1'b1; dtlb_asid_i = 1'b0;

    // ITLB alone: request visible one cycle after the miss.
    reset_dut();
    itlb_req_i = 1'b1;
    @(negedge clk_i);
    chk("idle_noreq", ptw_req_o, 1'b0);
    cyc();
    chk("req_asid", ptw_asid_o, 1'b1);
    grant_and_done(1'b0, IVA, 1'b1, 1'b0);

    // Tie after reset: I, D, I strictly alternating; error routed to the DTLB.
    reset_dut();
    itlb_req_i = 1'b1; dtlb_req_i = 1'b1;
    cyc();
    grant_and_done(1'b0, IVA, 1'b0, 1'b0);
    cyc();
    grant_and_done(1'b1, DVA, 1'b0, 1'b1);
    cyc();
    grant_and_done(1'b0, IVA, 1'b1, 1'b0);
    dtlb_req_i = 1'b0;

    // Flush in REQ with the walker not ready: back to IDLE, no grant.
    reset_dut();
    itlb_req_i = 1'b1;
    cyc();
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flreq_nognt", {itlb_gnt_o, dtlb_gnt_o}, 2'b00);
    cyc();
    flush_i = 1'b0; itlb_req_i = 1'b0;
    @(negedge clk_i);
    chk("flreq_idle", busy_o, 1'b0);
    chk("flreq_noreq", ptw_req_o, 1'b0);

    // Flush in WALK, done three cycles later: result dropped via DRAIN.
    reset_dut();
    itlb_req_i = 1'b1;
    cyc();
    ptw_ready_i = 1'b1; gq.push_back(2'b10);
    cyc();
    ptw_ready_i = 1'b0; itlb_req_i = 1'b0; flush_i = 1'b1;
    cyc();
    flush_i = 1'b0; dtlb_req_i = 1'b1;
    @(negedge clk_i);
    chk("drain_busy", busy_o, 1'b1);
    chk("drain_noarb", ptw_req_o, 1'b0);
    cyc();
    cyc();
    ptw_done_i = 1'b1; ptw_update_i.valid = 1'b1; dtlb_req_i = 1'b0;
    uq.push_back(4'b0000);
    @(negedge clk_i);
    chk("drain_busy_done", busy_o, 1'b1);
    cyc();
    ptw_done_i = 1'b0; ptw_update_i = '0;
    @(negedge clk_i);
    chk("drain_exit", busy_o, 1'b0);
`ifdef PTW_ARB_PERF_EN
    chk("perf_aborts", perf_flush_aborts_o, 32'd1);
    chk("perf_iwalks", perf_itlb_walks_o, 32'd1);
`endif

    // Flush together with a faulting done: nothing reaches either TLB.
    reset_dut();
    dtlb_req_i = 1'b1;
    cyc();
    ptw_ready_i = 1'b1; gq.push_back(2'b01);
    cyc();
    ptw_ready_i = 1'b0; dtlb_req_i = 1'b0;
    flush_i = 1'b1; ptw_done_i = 1'b1; ptw_error_i = 1'b1; ptw_update_i.valid = 1'b1;
    uq.push_back(4'b0000);
    cyc();
    flush_i = 1'b0; ptw_done_i = 1'b0; ptw_error_i = 1'b0; ptw_update_i = '0;
    @(negedge clk_i);
    chk("fldone_idle", busy_o, 1'b0);

    // Reset during WALK: late done ignored, next tie goes to the ITLB.
    reset_dut();
    dtlb_req_i = 1'b1;
    cyc();
    ptw_ready_i = 1'b1; gq.push_back(2'b01);
    cyc();
    ptw_ready_i = 1'b0; dtlb_req_i = 1'b0; rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rstwalk_idle", busy_o, 1'b0);
    cyc();
    ptw_done_i = 1'b1; ptw_update_i.valid = 1'b1;
    uq.push_back(4'b0000);
    cyc();
    ptw_done_i = 1'b0; ptw_update_i = '0;
    itlb_req_i = 1'b1; dtlb_req_i = 1'b1;
    cyc();
    grant_and_done(1'b0, IVA, 1'b1, 1'b0);
    dtlb_req_i = 1'b0;
    cyc();

    chk("sb_gnt_left", gq.size(), 0);
    chk("sb_upd_left", uq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
